taxi_axis_frame_trunc: RTL and testbench

AXI4-Stream frame length limiter for the stream datapath, placed directly upstream of `taxi_axis_register`. Frames no longer than a runtime-configured beat limit pass through unchanged. An over-length frame is cut at the limit: the block forces `tlast` on the limit beat and silently discards the remaining input beats up to and including the original `tlast`. The datapath is combinational with zero latency, so the downstream register stage provides the timing break.

---
 rtl/taxi_axis_pkg.sv | 12 +
 rtl/taxi_axis_if.sv | 36 +++
 rtl/taxi_axis_frame_trunc.sv | 168 ++++++++++++++++
 tb/tb_taxi_axis_frame_trunc.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/taxi_axis_pkg.sv
// Shared stream-datapath definitions: frame truncation FSM states and the
// tuser bit used to flag truncated frames.
package taxi_axis_pkg;

    typedef enum logic {
        PASS = 1'b0,
        DROP = 1'b1
    } taxi_axis_trunc_state_t;

    localparam int unsigned TAXI_AXIS_TRUNC_USER_BIT = 0;

endpackage

// File: rtl/taxi_axis_if.sv
// AXI4-Stream interface bundle; src drives the stream, snk consumes it.
interface taxi_axis_if #(
    parameter int DATA_W  = 8,
    parameter bit KEEP_EN = (DATA_W > 8),
    parameter int KEEP_W  = (DATA_W + 7) / 8,
    parameter bit STRB_EN = 1'b0,
    parameter bit LAST_EN = 1'b1,
    parameter bit ID_EN   = 1'b0,
    parameter int ID_W    = 8,
    parameter bit DEST_EN = 1'b0,
    parameter int DEST_W  = 8,
    parameter bit USER_EN = 1'b0,
    parameter int USER_W  = 1
);

    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic [KEEP_W-1:0] tstrb;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [ID_W-1:0]   tid;
    logic [DEST_W-1:0] tdest;
    logic [USER_W-1:0] tuser;

    modport src (
        output tdata, tkeep, tstrb, tvalid, tlast, tid, tdest, tuser,
        input  tready
    );

    modport snk (
        input  tdata, tkeep, tstrb, tvalid, tlast, tid, tdest, tuser,
        output tready
    );

endinterface

// File: rtl/taxi_axis_frame_trunc.sv
// Zero-latency AXI4-Stream frame length limiter: cuts frames at cfg_max_beats.
// Optional TAXI_AXIS_FRAME_TRUNC_MARK_EN sets tuser[0] on the forced-tlast beat.
module taxi_axis_frame_trunc
    import taxi_axis_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,

    taxi_axis_if.snk         s_axis,
    taxi_axis_if.src         m_axis,

    input  logic [LEN_W-1:0] cfg_max_beats,

    output logic             stat_trunc,
    output logic             stat_frame,
    output logic [LEN_W-1:0] stat_frame_beats
);

    localparam int DATA_W  = s_axis.DATA_W;
    localparam int KEEP_W  = s_axis.KEEP_W;
    localparam bit KEEP_EN = s_axis.KEEP_EN && m_axis.KEEP_EN;
    localparam bit STRB_EN = s_axis.STRB_EN && m_axis.STRB_EN;
    localparam bit S_LAST_EN = s_axis.LAST_EN;
    localparam bit M_LAST_EN = m_axis.LAST_EN;
    localparam bit ID_EN   = s_axis.ID_EN && m_axis.ID_EN;
    localparam bit DEST_EN = s_axis.DEST_EN && m_axis.DEST_EN;
    localparam bit USER_EN = s_axis.USER_EN && m_axis.USER_EN;

    if (m_axis.DATA_W != DATA_W) begin : g_chk_data_w
        $fatal(1, "taxi_axis_frame_trunc: DATA_W mismatch between s_axis and m_axis");
    end

    if (m_axis.KEEP_W != KEEP_W) begin : g_chk_keep_w
        $fatal(1, "taxi_axis_frame_trunc: KEEP_W mismatch between s_axis and m_axis");
    end

`ifdef TAXI_AXIS_FRAME_TRUNC_MARK_EN
    if (!USER_EN) begin : g_chk_mark_user
        $fatal(1, "taxi_axis_frame_trunc: marking truncated frames requires USER_EN");
    end
`endif

    taxi_axis_trunc_state_t state, state_next;

    logic [LEN_W-1:0] beat_cnt;
    logic [LEN_W-1:0] lim_reg;
    logic [LEN_W-1:0] limit;
    logic [LEN_W-1:0] cnt_inc;
    logic             s_last;
    logic             hit;
    logic             s_ready;
    logic             m_valid;
    logic             trunc_beat;
    logic             xfer;

    logic             trunc_q;
    logic             frame_q;
    logic [LEN_W-1:0] frame_beats_q;

    // The live config applies to the first beat; later beats use the latched copy.
    assign limit   = (beat_cnt == '0) ? cfg_max_beats : lim_reg;
    assign cnt_inc = beat_cnt + LEN_W'(1);
    assign hit     = (limit != '0) && (cnt_inc == limit);
    assign s_last  = S_LAST_EN ? s_axis.tlast : 1'b1;
    assign xfer    = s_axis.tvalid && s_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= PASS;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            PASS: begin
                if (xfer && trunc_beat) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                if (xfer && s_last) begin
                    state_next = PASS;
                end
            end
            default: state_next = PASS;
        endcase
    end

    always_comb begin
        s_ready    = 1'b0;
        m_valid    = 1'b0;
        trunc_beat = 1'b0;
        if (!rst) begin
            case (state)
                PASS: begin
                    s_ready    = m_axis.tready;
                    m_valid    = s_axis.tvalid;
                    trunc_beat = !s_last && hit;
                end
                DROP: begin
                    s_ready = 1'b1;
                end
                default: begin
                    s_ready = 1'b0;
                end
            endcase
        end
    end

    assign s_axis.tready = s_ready;
    assign m_axis.tvalid = m_valid;
    assign m_axis.tdata  = s_axis.tdata;
    assign m_axis.tkeep  = KEEP_EN ? s_axis.tkeep : '1;
    assign m_axis.tstrb  = STRB_EN ? s_axis.tstrb : m_axis.tkeep;
    assign m_axis.tlast  = M_LAST_EN ? (s_last || trunc_beat) : 1'b1;
    assign m_axis.tid    = ID_EN ? s_axis.tid : '0;
    assign m_axis.tdest  = DEST_EN ? s_axis.tdest : '0;

    always_comb begin
        m_axis.tuser = USER_EN ? s_axis.tuser : '0;
`ifdef TAXI_AXIS_FRAME_TRUNC_MARK_EN
        if (trunc_beat) begin
            m_axis.tuser[TAXI_AXIS_TRUNC_USER_BIT] = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt      <= '0;
            lim_reg       <= '0;
            trunc_q       <= 1'b0;
            frame_q       <= 1'b0;
            frame_beats_q <= '0;
        end else begin
            trunc_q <= 1'b0;
            frame_q <= 1'b0;
            if (state == PASS && xfer) begin
                if (beat_cnt == '0) begin
                    lim_reg <= cfg_max_beats;
                end
                if (s_last) begin
                    beat_cnt      <= '0;
                    frame_q       <= 1'b1;
                    frame_beats_q <= (beat_cnt == '1) ? beat_cnt : cnt_inc;
                end else if (hit) begin
                    beat_cnt      <= '0;
                    trunc_q       <= 1'b1;
                    frame_q       <= 1'b1;
                    frame_beats_q <= limit;
                end else if (!(limit == '0 && beat_cnt == '1)) begin
                    beat_cnt <= cnt_inc;
                end
            end
        end
    end

    // Status is forced low for the whole reset window, not just after the first edge.
    assign stat_trunc       = rst ? 1'b0 : trunc_q;
    assign stat_frame       = rst ? 1'b0 : frame_q;
    assign stat_frame_beats = rst ? '0 : frame_beats_q;

endmodule

// File: tb/tb_taxi_axis_frame_trunc.sv
// Directed bench for taxi_axis_frame_trunc with an index-based frame model.
module tb_taxi_axis_frame_trunc;

`ifdef TAXI_AXIS_FRAME_TRUNC_MARK_EN
    localparam bit MARK = 1'b1;
`else
    localparam bit MARK = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [15:0] cfg_max_beats;
    logic        stat_trunc;
    logic        stat_frame;
    logic [15:0] stat_frame_beats;

    int   total = 0;
    int   bad   = 0;
    bit   bp    = 1'b0;
    bit   exp_sf = 1'b0;
    bit   exp_st = 1'b0;
    logic [15:0] exp_sfb = '0;

    taxi_axis_if #(.DATA_W(8), .USER_EN(1'b1), .USER_W(1)) s_if ();
    taxi_axis_if #(.DATA_W(8), .USER_EN(1'b1), .USER_W(1)) m_if ();

    taxi_axis_frame_trunc #(.LEN_W(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .s_axis           (s_if),
        .m_axis           (m_if),
        .cfg_max_beats    (cfg_max_beats),
        .stat_trunc       (stat_trunc),
        .stat_frame       (stat_frame),
        .stat_frame_beats (stat_frame_beats)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives one frame; beat i carries base+i*step. Beat i is forwarded iff
    // lim==0 or i<lim, and carries tlast if it is the input last or index lim-1.
    task automatic run_frame(input int len, input int base, input int step, input int lim);
        int   i = 0;
        int   guard = 0;
        bit   pass, ilast, olast, trunc, acc;
        logic [7:0] d;
        cfg_max_beats = 16'(lim);
        while (i < len) begin
            d     = 8'(base + i * step);
            ilast = (i == len - 1);
            pass  = (lim == 0) || (i < lim);
            olast = ilast || (lim != 0 && i == lim - 1);
            trunc = pass && olast && !ilast;
            s_if.tvalid = 1'b1;
            s_if.tdata  = d;
            s_if.tlast  = ilast;
            s_if.tuser  = d[4];
            m_if.tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            total++;
            if (stat_frame !== exp_sf || stat_trunc !== exp_st || stat_frame_beats !== exp_sfb) begin
                bad++;
                $display("FAIL frame_stat beat=%0d: got frame=%b trunc=%b beats=%0d, need frame=%b trunc=%b beats=%0d",
                         i, stat_frame, stat_trunc, stat_frame_beats, exp_sf, exp_st, exp_sfb);
            end
            total++;
            if (pass) begin
                if (m_if.tvalid !== 1'b1 || m_if.tdata !== d || m_if.tlast !== olast ||
                    m_if.tuser !== (d[4] | (MARK & trunc)) || s_if.tready !== m_if.tready) begin
                    bad++;
                    $display("FAIL pass_beat %0d: got v=%b d=%h l=%b u=%b rdy=%b, need v=1 d=%h l=%b u=%b rdy=%b",
                             i, m_if.tvalid, m_if.tdata, m_if.tlast, m_if.tuser, s_if.tready,
                             d, olast, d[4] | (MARK & trunc), m_if.tready);
                end
            end else begin
                if (m_if.tvalid !== 1'b0 || s_if.tready !== 1'b1) begin
                    bad++;
                    $display("FAIL drop_beat %0d: got v=%b rdy=%b, need v=0 rdy=1",
                             i, m_if.tvalid, s_if.tready);
                end
            end
            acc = pass ? m_if.tready : 1'b1;
            @(posedge clk);
            #1;
            exp_sf = acc && pass && olast;
            exp_st = exp_sf && !ilast;
            if (exp_sf) exp_sfb = 16'(i + 1);
            if (acc) i++;
            guard++;
            if (guard > 20 * len + 100) begin
                total++;
                bad++;
                $display("FAIL timeout: frame stuck at beat %0d of %0d", i, len);
                break;
            end
        end
        s_if.tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            total++;
            if (m_if.tvalid !== 1'b0 || stat_frame !== exp_sf || stat_trunc !== exp_st ||
                stat_frame_beats !== exp_sfb) begin
                bad++;
                $display("FAIL idle: got v=%b frame=%b trunc=%b beats=%0d, need v=0 frame=%b trunc=%b beats=%0d",
                         m_if.tvalid, stat_frame, stat_trunc, stat_frame_beats, exp_sf, exp_st, exp_sfb);
            end
            @(posedge clk);
            #1;
            exp_sf = 1'b0;
            exp_st = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_if.tvalid = 1'b1;
        s_if.tdata  = 8'h5a;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (s_if.tready !== 1'b0 || m_if.tvalid !== 1'b0 || stat_frame !== 1'b0 ||
                stat_trunc !== 1'b0 || stat_frame_beats !== 16'd0) begin
                bad++;
                $display("FAIL reset: got rdy=%b v=%b frame=%b trunc=%b beats=%0d, need all 0",
                         s_if.tready, m_if.tvalid, stat_frame, stat_trunc, stat_frame_beats);
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        s_if.tvalid = 1'b0;
        exp_sf = 1'b0;
        exp_st = 1'b0;
        exp_sfb = '0;
        idle(1);
    endtask

    task automatic test_short_frame();
        run_frame(3, 8'h11, 8'h11, 4);
        idle(1);
        total++;
        if (stat_frame_beats !== 16'd3) begin
            bad++;
            $display("FAIL short_beats: got %0d, need 3", stat_frame_beats);
        end
    endtask

    task automatic test_exact_length();
        run_frame(4, 8'h40, 1, 4);
        idle(2);
    endtask

    task automatic test_truncate();
        run_frame(7, 0, 1, 4);
        run_frame(2, 8'h0a, 1, 4);
        idle(1);
        total++;
        if (stat_frame_beats !== 16'd2) begin
            bad++;
            $display("FAIL trunc_next_beats: got %0d, need 2", stat_frame_beats);
        end
    endtask

    task automatic test_limit_one();
        run_frame(3, 8'h70, 1, 1);
        run_frame(1, 8'h80, 1, 1);
        run_frame(2, 8'h90, 1, 1);
        idle(2);
    endtask

    task automatic test_no_limit();
        run_frame(1000, 0, 1, 0);
        idle(1);
        total++;
        if (stat_frame_beats !== 16'd1000) begin
            bad++;
            $display("FAIL nolimit_beats: got %0d, need 1000", stat_frame_beats);
        end
    endtask

    task automatic test_back_to_back_bp();
        bp = 1'b1;
        for (int f = 0; f < 200; f++) begin
            run_frame(int'($urandom_range(1, 9)), int'($urandom_range(0, 255)), 1, 5);
        end
        bp = 1'b0;
        idle(2);
    endtask

    task automatic test_reset_mid();
        cfg_max_beats = 16'd4;
        s_if.tvalid = 1'b1;
        s_if.tdata  = 8'h60;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
        m_if.tready = 1'b1;
        @(negedge clk);
        total++;
        if (m_if.tvalid !== 1'b1 || m_if.tdata !== 8'h60 || s_if.tready !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_beat1: got v=%b d=%h rdy=%b, need v=1 d=60 rdy=1",
                     m_if.tvalid, m_if.tdata, s_if.tready);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        s_if.tdata = 8'h61;
        @(negedge clk);
        total++;
        if (s_if.tready !== 1'b0 || m_if.tvalid !== 1'b0 || stat_frame !== 1'b0 ||
            stat_trunc !== 1'b0 || stat_frame_beats !== 16'd0) begin
            bad++;
            $display("FAIL rstmid_hold: got rdy=%b v=%b frame=%b trunc=%b beats=%0d, need all 0",
                     s_if.tready, m_if.tvalid, stat_frame, stat_trunc, stat_frame_beats);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_sf = 1'b0;
        exp_st = 1'b0;
        exp_sfb = '0;
        run_frame(4, 8'h62, 1, 4);
        idle(1);
        total++;
        if (stat_frame_beats !== 16'd4) begin
            bad++;
            $display("FAIL rstmid_beats: got %0d, need 4", stat_frame_beats);
        end
    endtask

    initial begin
        rst = 1'b1;
        cfg_max_beats = 16'd4;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '1;
        s_if.tstrb  = '1;
        s_if.tlast  = 1'b0;
        s_if.tid    = '0;
        s_if.tdest  = '0;
        s_if.tuser  = '0;
        m_if.tready = 1'b1;
        test_reset();
        test_short_frame();
        test_exact_length();
        test_truncate();
        test_limit_one();
        test_no_limit();
        test_back_to_back_bp();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
